// File: rtl/chacha20_stream.sv
// chacha20_stream: XORs a 32-bit word stream with ChaCha20 keystream blocks produced by an attached core.
// One 512-bit block is buffered at a time; the next block is requested only after its 16th word is used.
module chacha20_stream #(
  parameter int ROUNDS = 20
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_init,
  input  logic [255:0] i_key,
  input  logic [63:0]  i_nonce,
  input  logic [63:0]  i_init_counter,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [31:0]  i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [31:0]  o_out_data,
  output logic         o_core_start,
  output logic [255:0] o_core_key,
  output logic [63:0]  o_core_nonce,
  output logic [63:0]  o_core_index,
  input  logic         i_core_done,
  input  logic [511:0] i_core_out
);
  typedef enum logic [1:0] {IDLE, START, WAIT, STREAM} state_t;
  state_t         r_state;
  logic [63:0]    r_counter;
  logic [511:0]   r_buf;
  logic [3:0]     r_idx;
  logic           r_wait_first;
  logic           w_in_hs;
  logic           w_out_hs;
  logic [31:0]    w_word;
  if (ROUNDS < 2 || ROUNDS % 2 != 0) begin : g_rounds_check
    $error("chacha20_stream: ROUNDS must be a positive even number");
  end
  // init and reset take priority, so no input word may be accepted in their cycle
  assign o_in_ready = (r_state == STREAM) && !i_init && !i_rst && (!o_out_valid || i_out_ready);
  assign w_in_hs    = i_in_valid && o_in_ready;
  assign w_out_hs   = o_out_valid && i_out_ready;
  assign w_word     = r_buf[{~r_idx, 5'b0} +: 32];
  for (genvar i = 0; i < 8; i++) begin : g_index
    assign o_core_index[8*i +: 8] = r_counter[56-8*i +: 8];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      o_out_valid  <= 1'b0;
      o_core_start <= 1'b0;
      o_out_data   <= '0;
      r_counter    <= '0;
      r_idx        <= '0;
      o_core_key   <= '0;
      o_core_nonce <= '0;
      r_wait_first <= 1'b0;
    end else if (i_init) begin
      o_core_key   <= i_key;
      o_core_nonce <= i_nonce;
      r_counter    <= i_init_counter;
      r_idx        <= '0;
      o_out_valid  <= 1'b0;
      o_core_start <= 1'b1;
      r_state      <= START;
    end else begin
      o_core_start <= 1'b0;
      if (w_out_hs) o_out_valid <= 1'b0;
      case (r_state)
        START: begin
          r_wait_first <= 1'b1;
          r_state      <= WAIT;
        end
        // a done in the first WAIT cycle belongs to a run that init aborted
        WAIT: begin
          r_wait_first <= 1'b0;
          if (i_core_done && !r_wait_first) begin
            r_buf   <= i_core_out;
            r_idx   <= '0;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_in_hs) begin
            o_out_data  <= i_in_data ^ w_word;
            o_out_valid <= 1'b1;
            r_idx       <= r_idx + 4'd1;
            if (r_idx == 4'd15) begin
              r_counter    <= r_counter + 64'd1;
              o_core_start <= 1'b1;
              r_state      <= START;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
